// File: rtl/load_store_unit_if.sv
// Bundles the LSU request, data-memory and response channels.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // Pipeline request (EX/MEM -> LSU)
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;

  // Data-memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  // Response to the load-truncation stage
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_offset;
  logic [2:0]            rsp_funct3;
  logic                  rsp_write;
  logic                  rsp_misaligned;

  // Environment side: drives requests, memory replies and response ready
  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_offset, rsp_funct3, rsp_write, rsp_misaligned,
    output rsp_ready
  );

  // LSU side
  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_offset, rsp_funct3, rsp_write, rsp_misaligned,
    input  rsp_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: alignment check, byte enables, store-lane replication,
// and a four-state FSM that absorbs variable memory latency.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_funct3;
  logic [1:0]            r_offset;
  logic                  r_misaligned;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_accept;
  logic [1:0]            w_off;
  logic                  w_misaligned;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wdata;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_off    = bus.req_addr[1:0];

  // Decode size from funct3[1:0]: alignment error, byte-enable mask, store lanes
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = bus.req_wdata;
    unique case (bus.req_funct3[1:0])
      2'b00: begin
        w_be    = 4'(4'b0001 << w_off);
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_off[0];
        w_be         = 4'(4'b0011 << w_off);
        w_wdata      = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_misaligned = (w_off != 2'b00);
      end
      default: begin
        w_misaligned = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req_valid) w_state_nxt = w_misaligned ? S_RESP : S_REQ;
      S_REQ:  if (bus.mem_gnt)    w_state_nxt = S_WAIT;
      S_WAIT: if (bus.mem_rvalid) w_state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the access on acceptance; hold it for the memory and response phases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_funct3     <= 3'b000;
      r_offset     <= 2'b00;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_write      <= bus.req_write;
      r_addr       <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
      r_be         <= w_be;
      r_wdata      <= w_wdata;
      r_funct3     <= bus.req_funct3;
      r_offset     <= w_off;
      r_misaligned <= w_misaligned;
    end
  end

  // Read data: cleared on accept, captured on completion (stores return 0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (w_accept) begin
      r_rdata <= '0;
    end else if ((r_state == S_WAIT) && bus.mem_rvalid) begin
      r_rdata <= r_write ? '0 : bus.mem_rdata;
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.mem_req        = (r_state == S_REQ);
  assign bus.mem_we         = (r_state == S_REQ) && r_write;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_be         = r_be;
  assign bus.mem_wdata      = r_wdata;
  assign bus.rsp_valid      = (r_state == S_RESP);
  assign bus.rsp_rdata      = r_rdata;
  assign bus.rsp_offset     = r_offset;
  assign bus.rsp_funct3     = r_funct3;
  assign bus.rsp_write      = r_write;
  assign bus.rsp_misaligned = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario.
module tb_load_store_unit;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata  = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    n_total++;
    if ({bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b exp 1000",
               {bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid});
    else n_pass++;
    n_total++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'h0)
      $display("FAIL reset_mem: addr %h be %b wdata %h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    n_total++;
    if ({bus.rsp_rdata, bus.rsp_offset, bus.rsp_funct3, bus.rsp_write, bus.rsp_misaligned} !== 39'h0)
      $display("FAIL reset_rsp: rdata %h off %0d f3 %b wr %b mis %b", bus.rsp_rdata,
               bus.rsp_offset, bus.rsp_funct3, bus.rsp_write, bus.rsp_misaligned);
    else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  // LW 0x1000, immediate grant, data one cycle later
  task automatic test_lw();
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = 32'h1000; bus.req_funct3 = 3'b010;
    n_total++;
    if (bus.req_ready !== 1'b1) $display("FAIL lw_ready: got %b exp 1", bus.req_ready);
    else n_pass++;
    step();                                   // N+1
    bus.req_valid = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {2'b10, 32'h1000, 4'b1111})
      $display("FAIL lw_memreq: req %b we %b addr %h be %b exp 1 0 00001000 1111",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
    else n_pass++;
    bus.mem_gnt = 1'b1;
    step();                                   // N+2
    bus.mem_gnt = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.rsp_valid} !== 2'b00)
      $display("FAIL lw_wait: mem_req %b rsp_valid %b exp 0 0", bus.mem_req, bus.rsp_valid);
    else n_pass++;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    step();                                   // N+3
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    n_total++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_offset, bus.rsp_funct3, bus.rsp_write,
         bus.rsp_misaligned} !== {1'b1, 32'hDEADBEEF, 2'd0, 3'b010, 1'b0, 1'b0})
      $display("FAIL lw_rsp: v %b rdata %h off %0d f3 %b wr %b mis %b exp 1 deadbeef 0 010 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_offset, bus.rsp_funct3,
               bus.rsp_write, bus.rsp_misaligned);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_total++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL lw_done: rsp_valid %b req_ready %b exp 0 1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  // SB 0x2003: top-lane enable, replicated byte, read data forced to 0
  task automatic test_sb();
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = 32'h2003; bus.req_funct3 = 3'b000; bus.req_wdata = 32'h000000A5;
    step();
    bus.req_valid = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}
        !== {2'b11, 32'h2000, 4'b1000, 32'hA5A5A5A5})
      $display("FAIL sb_memreq: req %b we %b addr %h be %b wdata %h exp 1 1 00002000 1000 a5a5a5a5",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    n_total++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_offset, bus.rsp_misaligned}
        !== {2'b11, 32'h0, 2'd3, 1'b0})
      $display("FAIL sb_rsp: v %b wr %b rdata %h off %0d mis %b exp 1 1 0 3 0",
               bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.rsp_offset, bus.rsp_misaligned);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // LHU 0x3002: grant after 3 stall cycles, stray rvalid in REQ, late rvalid
  task automatic test_lhu_delayed();
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = 32'h3002; bus.req_funct3 = 3'b101;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {2'b10, 32'h3000, 4'b1100})
        $display("FAIL lhu_req_stable[%0d]: req %b we %b addr %h be %b exp 1 0 00003000 1100",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
      else n_pass++;
      bus.mem_gnt    = (i == 3);
      bus.mem_rvalid = (i == 1);
      bus.mem_rdata  = (i == 1) ? 32'hBADBAD00 : 32'h0;
      step();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({bus.mem_req, bus.rsp_valid} !== 2'b00)
        $display("FAIL lhu_wait[%0d]: mem_req %b rsp_valid %b exp 0 0", i, bus.mem_req, bus.rsp_valid);
      else n_pass++;
      step();
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE0000;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    n_total++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_offset, bus.rsp_funct3, bus.rsp_misaligned}
        !== {1'b1, 32'hCAFE0000, 2'd2, 3'b101, 1'b0})
      $display("FAIL lhu_rsp: v %b rdata %h off %0d f3 %b mis %b exp 1 cafe0000 2 101 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_offset, bus.rsp_funct3, bus.rsp_misaligned);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // Misaligned LH/LW and reserved size: response one cycle after accept, no memory traffic
  task automatic test_misaligned();
    logic [31:0] addrs [3];
    logic [2:0]  f3s   [3];
    addrs[0] = 32'h4001; f3s[0] = 3'b001;
    addrs[1] = 32'h4002; f3s[1] = 3'b010;
    addrs[2] = 32'h4000; f3s[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b0;
      bus.req_addr = addrs[i]; bus.req_funct3 = f3s[i];
      step();
      bus.req_valid = 1'b0;
      n_total++;
      if ({bus.rsp_valid, bus.rsp_misaligned, bus.mem_req, bus.rsp_rdata, bus.rsp_offset,
           bus.rsp_funct3} !== {3'b110, 32'h0, addrs[i][1:0], f3s[i]})
        $display("FAIL misaligned[%0d]: v %b mis %b mem_req %b rdata %h off %0d f3 %b exp 1 1 0 0 %0d %b",
                 i, bus.rsp_valid, bus.rsp_misaligned, bus.mem_req, bus.rsp_rdata,
                 bus.rsp_offset, bus.rsp_funct3, addrs[i][1:0], f3s[i]);
      else n_pass++;
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      n_total++;
      if ({bus.mem_req, bus.rsp_valid, bus.req_ready} !== 3'b001)
        $display("FAIL misaligned_done[%0d]: mem_req %b rsp_valid %b req_ready %b exp 0 0 1",
                 i, bus.mem_req, bus.rsp_valid, bus.req_ready);
      else n_pass++;
    end
  endtask

  // Response stalled 5 cycles with the next request pending
  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = 32'h5004; bus.req_funct3 = 3'b010;
    step();
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11112222;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = 32'h5008; bus.req_funct3 = 3'b010; bus.req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({bus.rsp_valid, bus.req_ready, bus.mem_req, bus.rsp_rdata, bus.rsp_offset,
           bus.rsp_funct3, bus.rsp_write} !== {3'b100, 32'h11112222, 2'd0, 3'b010, 1'b0})
        $display("FAIL b2b_hold[%0d]: v %b rr %b mreq %b rdata %h off %0d f3 %b wr %b exp 1 0 0 11112222 0 010 0",
                 i, bus.rsp_valid, bus.req_ready, bus.mem_req, bus.rsp_rdata,
                 bus.rsp_offset, bus.rsp_funct3, bus.rsp_write);
      else n_pass++;
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_total++;
    if ({bus.rsp_valid, bus.req_ready, bus.mem_req} !== 3'b010)
      $display("FAIL b2b_idle: v %b rr %b mreq %b exp 0 1 0", bus.rsp_valid, bus.req_ready, bus.mem_req);
    else n_pass++;
    step();
    bus.req_valid = 1'b0;
    n_total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}
        !== {2'b11, 32'h5008, 4'b1111, 32'h0BADF00D})
      $display("FAIL b2b_second: req %b we %b addr %h be %b wdata %h exp 1 1 00005008 1111 0badf00d",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    n_total++;
    if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata} !== {2'b11, 32'h0})
      $display("FAIL b2b_rsp: v %b wr %b rdata %h exp 1 1 0", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // Reset asserted during WAIT; a later stray rvalid must be ignored
  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = 32'h6000; bus.req_funct3 = 3'b010;
    step();
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid, bus.mem_addr, bus.mem_be}
        !== {4'b1000, 32'h0, 4'b0000})
      $display("FAIL reset_mid: rr %b mreq %b we %b v %b addr %h be %b exp 1 0 0 0 0 0000",
               bus.req_ready, bus.mem_req, bus.mem_we, bus.rsp_valid, bus.mem_addr, bus.mem_be);
    else n_pass++;
    #2;
    reset_n = 1'b1;
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {2'b01, 32'h0})
        $display("FAIL reset_stray[%0d]: v %b rr %b rdata %h exp 0 1 0",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_lw();
    test_sb();
    test_lhu_delayed();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
